// File: rtl/ex_alu_pkg.sv
// Shared constants for the EX-stage ALU: operand width, ALU control
// encodings, FSM states and the single-cycle operation helper.
package ex_alu_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    // ALU control codes shared with the decoder (ADDI / LW / SW use ADD,
    // BEQ compare uses SUB).
    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_XOR  = 3'b001,
        ALU_SLL  = 3'b010,
        ALU_ADD  = 3'b011,
        ALU_SUB  = 3'b100,
        ALU_MUL  = 3'b101,
        ALU_SRAI = 3'b110,
        ALU_RSVD = 3'b111
    } alu_ctrl_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } alu_state_e;

    // Result of every op that completes in one cycle; MUL and the reserved
    // code fall to zero here (MUL never takes this path).
    function automatic logic [WIDTH-1:0] alu_single(
        input logic [2:0]       ctrl,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [4:0] sh;
        sh = b[4:0];
        case (ctrl)
            ALU_AND:  alu_single = a & b;
            ALU_XOR:  alu_single = a ^ b;
            ALU_SLL:  alu_single = a << sh;
            ALU_ADD:  alu_single = a + b;
            ALU_SUB:  alu_single = a - b;
            ALU_SRAI: alu_single = $signed(a) >>> sh;
            default:  alu_single = {WIDTH{1'b0}};
        endcase
    endfunction

endpackage

// File: rtl/ex_alu_if.sv
// Request/result bundle between the EX stage control and the ALU.
interface ex_alu_if;
    import ex_alu_pkg::*;

    logic             start;
    logic [2:0]       ctrl;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             flush;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             done;
    logic             busy;

    modport master (
        output start, ctrl, data1, data2, flush,
        input  result, zero, done, busy
    );

    modport slave (
        input  start, ctrl, data1, data2, flush,
        output result, zero, done, busy
    );

endinterface

// File: rtl/ex_alu_mul_iter.sv
// mul_iter: shift-add multiplier core. One partial product per clock; p_o is
// the accumulator including the current step, so the owner can capture the
// final product on the same edge that performs iteration 31.
module ex_alu_mul_iter
    import ex_alu_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] p_o,
    output logic             last_o
);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_step_s;

    assign acc_step_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign p_o        = acc_step_s;
    assign last_o     = (cnt_q == 5'd31);

    // Next-state: flush clears, load seeds operands, otherwise one iteration.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            mcand_d  = {WIDTH{1'b0}};
            mplier_d = {WIDTH{1'b0}};
            acc_d    = {WIDTH{1'b0}};
            cnt_d    = 5'd0;
        end else if (load_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = {WIDTH{1'b0}};
            cnt_d    = 5'd0;
        end else begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = acc_step_s;
            cnt_d    = cnt_q + 5'd1;
        end
    end

    // Datapath registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {WIDTH{1'b0}};
            cnt_q    <= 5'd0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/ex_alu.sv
// EX-stage ALU: single-cycle ops finish in one clock, MUL iterates for 32
// clocks behind busy. Result, zero and done are registered for EX/MEM.
module ex_alu
    import ex_alu_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    ex_alu_if.slave bus
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic             mul_load_s;
    logic             mul_last_s;
    logic [WIDTH-1:0] mul_p_s;

    ex_alu_mul_iter u_mul_iter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (mul_load_s),
        .flush_i (bus.flush),
        .a_i     (bus.data1),
        .b_i     (bus.data2),
        .p_o     (mul_p_s),
        .last_o  (mul_last_s)
    );

    // FSM next-state and result selection; flush always beats a request
    // or a completing multiply.
    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        done_d     = 1'b0;
        mul_load_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (bus.start) begin
                    if (bus.ctrl == ALU_MUL) begin
                        mul_load_s = 1'b1;
                        state_d    = ST_MUL_RUN;
                    end else begin
                        result_d = alu_single(bus.ctrl, bus.data1, bus.data2);
                        done_d   = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL_RUN: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (mul_last_s) begin
                    result_d = mul_p_s;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_MUL_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        zero_d = (result_d == {WIDTH{1'b0}});
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            result_q <= {WIDTH{1'b0}};
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.done   = done_q;
    assign bus.busy   = (state_q == ST_MUL_RUN);

endmodule

// File: tb/tb_ex_alu.sv
// Directed self-checking bench for ex_alu.
module tb_ex_alu;
    import ex_alu_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   passes;

    ex_alu_if bus();

    ex_alu u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue a single-cycle op and check result/zero/done at T+1, done low at T+2.
    task automatic single(input string tag, input logic [2:0] c,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        bus.start = 1'b1; bus.ctrl = c; bus.data1 = a; bus.data2 = b;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_result"}, bus.result, exp);
        check({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, exp == 32'd0});
        check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
        @(negedge clk);
        check({tag, "_done_low"}, {31'd0, bus.done}, 32'd0);
    endtask

    // Run a multiply; busy must last exactly 32 cycles, done/result at T+33.
    task automatic mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
        int busy_cnt;
        int early_done;
        busy_cnt   = 0;
        early_done = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.ctrl = ALU_MUL; bus.data1 = a; bus.data2 = b;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) early_done++;
            if (bus.busy) busy_cnt++;
            else break;
        end
        check({tag, "_busy_cycles"}, busy_cnt, 32'd32);
        check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
        check({tag, "_early_done"}, early_done, 32'd1);
        check({tag, "_result"}, bus.result, exp);
    endtask

    initial begin
        int dones;
        checks = 0;
        passes = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.flush = 1'b0; bus.ctrl = 3'b000;
        bus.data1 = 32'd0; bus.data2 = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_result", bus.result, 32'd0);
        check("rst_zero", {31'd0, bus.zero}, 32'd1);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;

        single("add", ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000);
        single("sub", ALU_SUB, 32'd5, 32'd5, 32'h00000000);
        single("xor", ALU_XOR, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0);
        single("and", ALU_AND, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00);
        single("sll", ALU_SLL, 32'h00000001, 32'd31, 32'h80000000);
        single("srai", ALU_SRAI, 32'h80000000, 32'd4, 32'hF8000000);
        single("srai_pos", ALU_SRAI, 32'h40000000, 32'h00000024, 32'h04000000);
        single("rsvd", ALU_RSVD, 32'h12345678, 32'h9ABCDEF0, 32'h00000000);

        // Back-to-back single-cycle ops with done every cycle.
        @(negedge clk);
        bus.start = 1'b1; bus.ctrl = ALU_ADD; bus.data1 = 32'd1; bus.data2 = 32'd1;
        @(negedge clk);
        check("b2b0_result", bus.result, 32'd2);
        check("b2b0_done", {31'd0, bus.done}, 32'd1);
        bus.ctrl = ALU_SUB; bus.data1 = 32'd10; bus.data2 = 32'd3;
        @(negedge clk);
        check("b2b1_result", bus.result, 32'd7);
        check("b2b1_done", {31'd0, bus.done}, 32'd1);
        bus.start = 1'b0;

        mul("mul_a", 32'h00010003, 32'h00020005, 32'h000B000F);
        mul("mul_b", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);

        // Start pulse during a MUL must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.ctrl = ALU_MUL; bus.data1 = 32'd7; bus.data2 = 32'd6;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.ctrl = ALU_ADD; bus.data1 = 32'd1; bus.data2 = 32'd1;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("ign_dones", dones, 32'd1);
        check("ign_result", bus.result, 32'h0000002A);

        // Flush at T+10 of a MUL.
        @(negedge clk);
        bus.start = 1'b1; bus.ctrl = ALU_MUL; bus.data1 = 32'd3; bus.data2 = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", {31'd0, bus.busy}, 32'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("flush_dones", dones, 32'd0);
        check("flush_result", bus.result, 32'h0000002A);

        // Flush together with a request in IDLE drops the request.
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.ctrl = ALU_ADD;
        bus.data1 = 32'd100; bus.data2 = 32'd1;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        check("fs_done", {31'd0, bus.done}, 32'd0);
        check("fs_result", bus.result, 32'h0000002A);
        check("fs_busy", {31'd0, bus.busy}, 32'd0);

        // Asynchronous reset in the middle of a MUL.
        @(negedge clk);
        bus.start = 1'b1; bus.ctrl = ALU_MUL; bus.data1 = 32'd9; bus.data2 = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_result", bus.result, 32'd0);
        check("arst_zero", {31'd0, bus.zero}, 32'd1);
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        single("post_rst_add", ALU_ADD, 32'd2, 32'd3, 32'd5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ex_alu.md
# ex_alu

Execute-stage ALU that consumes the 3-bit ALU control code and the two operands selected for the EX stage and produces a registered 32-bit result and zero flag for EX/MEM. Single-cycle ops (AND, XOR, SLL, ADD, SUB, SRAI) complete in one cycle. MUL runs a fixed 32-iteration shift-add sequence and holds `busy_o` so the hazard unit stalls IF/ID/EX. A `done_o` pulse marks every completed operation.

## Interface
- `WIDTH`, 32, operand/result width; only 32 is supported.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  operation request; accepted only when `busy_o`=0.
- `ctrl_i`  in  3  ALU control code (shared encodings below).
- `data1_i`  in  32  operand rs1.
- `data2_i`  in  32  operand rs2 or immediate.
- `flush_i`  in  1  abort any in-flight MUL; synchronous.
- `result_o`  out  32  registered result; holds its value until the next completion.
- `zero_o`  out  1  registered, equals (`result_o` == 0).
- `done_o`  out  1  one-cycle pulse in the cycle `result_o` first shows a new value.
- `busy_o`  out  1  high while a MUL is iterating; stall request.

## Operation
- Control encodings (shared): AND=000, XOR=001, SLL=010, ADD=011 (ADDI and LW/SW address also use 011), SUB=100 (BEQ compare also uses 100), MUL=101, SRAI=110, 111 reserved.
- AND and XOR are bitwise.
- ADD and SUB are modulo 2^32; there is no overflow flag.
- SLL shifts `data1_i` left by `data2_i[4:0]`. SRAI shifts `data1_i` right arithmetically by `data2_i[4:0]`.
- MUL produces the low 32 bits of the unsigned shift-add product, which is identical to the signed low word.
- Reserved code 111 gives result 0 and completes like a single-cycle op.
- FSM states: IDLE, MUL_RUN.
  - IDLE with `start_i`=1 and a non-MUL op: register the result, pulse `done_o` next cycle, stay in IDLE.
  - IDLE with `start_i`=1 and MUL: latch the multiplicand and multiplier, clear the accumulator, set count=0, go to MUL_RUN.
  - MUL_RUN: each cycle, if multiplier[0]=1 add the multiplicand to the accumulator; then shift the multiplicand left 1 and the multiplier right 1; count++.
  - MUL_RUN when count=31 completes: write the accumulator to `result_o`, go to IDLE, pulse `done_o` next cycle.
- `start_i` while `busy_o`=1 is ignored; the operand and control inputs are don't-care then.
- `flush_i`=1 in MUL_RUN: return to IDLE. No `done_o`, `result_o` and `zero_o` unchanged.
- `flush_i` and `start_i` in the same IDLE cycle: flush wins and the request is dropped.
- Reset, including mid-MUL: state IDLE, `result_o`=0, `zero_o`=1, `done_o`=0, `busy_o`=0, count=0, all datapath registers 0.

## Timing
- Non-MUL op accepted at edge T: `result_o`, `zero_o` and `done_o`=1 are visible in cycle T+1.
- MUL accepted at edge T: `busy_o`=1 during cycles T+1..T+32. Result and `done_o`=1 appear in cycle T+33. Fixed latency of 33 cycles, no early termination.
- `busy_o` is decoded combinationally from state==MUL_RUN, so the stall takes effect from the cycle after the accept edge.
- Back-to-back single-cycle ops are accepted every cycle, with `done_o` high every cycle.
- A new op may be accepted in the same cycle `done_o` is high for the previous one.

## Structure
- Control encodings and `WIDTH` go in the shared constants include, alongside the existing ALU control defines. No local redefinition.
- Sub-module `mul_iter` holds the multiplicand, multiplier, accumulator and 5-bit counter. Its ports are `clk_i`, `rst_i`, `load_i`, `flush_i`, `a_i`, `b_i`, `p_o`, `last_o`.
- `ex_alu` keeps the FSM, the single-cycle datapath and the output registers.

## Test plan
- Reset: assert `rst_i` mid-MUL. Required: `result_o`=0, `zero_o`=1, `busy_o`=0 immediately (asynchronous); after release, the next single-cycle op works.
- Single-cycle ops: ADD 0x7FFFFFFF+1 gives 0x80000000. SUB 5-5 gives 0 with `zero_o`=1. XOR 0xF0F0F0F0^0xFFFF0000 gives 0x0F0FF0F0. SLL 1 by 31 gives 0x80000000. SRAI 0x80000000 by 4 gives 0xF8000000. Each must show `done_o` at T+1.
- MUL 0x0001_0003 × 0x0002_0005 gives 0x000B_000F. MUL 0xFFFFFFFF × 0xFFFFFFFF gives 0x00000001. Required: `busy_o` for exactly 32 cycles, `done_o` at T+33.
- Start during MUL: pulse `start_i` with ADD at T+5. Required: ignored, MUL result unchanged, only one `done_o`.
- Flush: flush at T+10 of a MUL. Required: `busy_o` drops next cycle, no `done_o`, `result_o` keeps its prior value.
- Reserved code 111 with nonzero operands. Required: `result_o`=0, `zero_o`=1, `done_o` at T+1.
